// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: state encoding, default widths
// and the length code that stands for a full-memory load.
package prog_loader_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;

    // A length byte equal to this code requests 2^ADDR_W data bytes.
    localparam int LEN_FULL_CODE = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_FAIL
    } state_t;

    function automatic logic is_loading(input state_t s);
        return (s == S_LEN) || (s == S_DATA) || (s == S_CSUM);
    endfunction

endpackage

// File: rtl/prog_loader.sv
// Framed byte-stream loader: length, data, XOR checksum. Writes data into
// program memory and releases the CPU only after a good checksum.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int                ADDR_W    = DEF_ADDR_W,
    parameter int                DATA_W    = DEF_DATA_W,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              RESET,
    input  logic              START,
    input  logic [DATA_W-1:0] IN_DATA,
    input  logic              IN_VALID,
    output logic              IN_READY,
    output logic              WE,
    output logic [ADDR_W-1:0] WADDR,
    output logic [DATA_W-1:0] WDATA,
    output logic              CPU_RESET,
    output logic              RUN,
    output logic              BUSY,
    output logic              ERR
);

    // One extra bit so the full-memory count 2^ADDR_W is representable.
    localparam int               CNT_W      = ((DATA_W > ADDR_W) ? DATA_W : ADDR_W) + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(1) << ADDR_W;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  remaining_reg;
    logic [ADDR_W-1:0] index_reg;
    logic [DATA_W-1:0] acc_reg;
    logic              we_reg;
    logic [ADDR_W-1:0] waddr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic              run_reg;
    logic              accept;
    logic              last_data;

    assign IN_READY  = is_loading(state_reg);
    assign BUSY      = is_loading(state_reg);
    assign ERR       = (state_reg == S_FAIL);
    assign RUN       = run_reg;
    assign CPU_RESET = ~run_reg;
    assign WE        = we_reg;
    assign WADDR     = waddr_reg;
    assign WDATA     = wdata_reg;

    assign accept    = IN_VALID && IN_READY;
    assign last_data = (remaining_reg == CNT_W'(1));

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            S_IDLE: if (START) state_next = S_LEN;
            S_LEN:  if (accept) state_next = S_DATA;
            S_DATA: if (accept && last_data) state_next = S_CSUM;
            S_CSUM: if (accept) state_next = (acc_reg == IN_DATA) ? S_DONE : S_FAIL;
            S_DONE: if (START) state_next = S_LEN;
            S_FAIL: if (START) state_next = S_LEN;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            state_reg     <= S_IDLE;
            remaining_reg <= '0;
            index_reg     <= '0;
            acc_reg       <= '0;
            we_reg        <= 1'b0;
            waddr_reg     <= '0;
            wdata_reg     <= '0;
            run_reg       <= 1'b0;
        end else begin
            state_reg <= state_next;
            we_reg    <= 1'b0;
            // RUN waits one cycle in DONE so the last write has retired first.
            run_reg   <= (state_reg == S_DONE) && (state_next == S_DONE);
            if (accept) begin
                case (state_reg)
                    S_LEN: begin
                        remaining_reg <= (IN_DATA == DATA_W'(LEN_FULL_CODE)) ? FULL_COUNT
                                                                             : CNT_W'(IN_DATA);
                        index_reg     <= '0;
                        acc_reg       <= '0;
                    end
                    S_DATA: begin
                        we_reg        <= 1'b1;
                        waddr_reg     <= BASE_ADDR + index_reg;
                        wdata_reg     <= IN_DATA;
                        index_reg     <= index_reg + ADDR_W'(1);
                        acc_reg       <= acc_reg ^ IN_DATA;
                        remaining_reg <= remaining_reg - CNT_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: two instances (base 0x00 and 0xFE) share one stream
// and are compared every cycle against a frame-position reference model.
`timescale 1ns/1ps
module tb_prog_loader;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, valid;
    logic [7:0] data;

    logic       rdy0, we0, cr0, run0, busy0, err0;
    logic [7:0] wa0, wd0;
    logic       rdy1, we1, cr1, run1, busy1, err1;
    logic [7:0] wa1, wd1;

    prog_loader #(.ADDR_W(8), .DATA_W(8), .BASE_ADDR(8'h00)) dut0 (
        .clk(clk), .RESET(rst), .START(start), .IN_DATA(data), .IN_VALID(valid),
        .IN_READY(rdy0), .WE(we0), .WADDR(wa0), .WDATA(wd0),
        .CPU_RESET(cr0), .RUN(run0), .BUSY(busy0), .ERR(err0)
    );

    prog_loader #(.ADDR_W(8), .DATA_W(8), .BASE_ADDR(8'hFE)) dut1 (
        .clk(clk), .RESET(rst), .START(start), .IN_DATA(data), .IN_VALID(valid),
        .IN_READY(rdy1), .WE(we1), .WADDR(wa1), .WDATA(wd1),
        .CPU_RESET(cr1), .RUN(run1), .BUSY(busy1), .ERR(err1)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: tracks position inside the frame, not a state machine.
    bit         m_valid = 0;
    bit         m_loading, m_good, m_failed, m_run, m_we;
    int         m_pos, m_total, m_age;
    logic [7:0] m_xor, m_wdata, m_waddr0, m_waddr1;

    always @(posedge clk) begin
        bit was_good;
        m_valid = 1;
        if (rst) begin
            m_loading = 0; m_good = 0; m_failed = 0; m_run = 0; m_we = 0;
            m_pos = 0; m_total = 0; m_age = 0;
            m_xor = 0; m_wdata = 0; m_waddr0 = 0; m_waddr1 = 0;
        end else begin
            was_good = m_good;
            m_we = 0;
            if (m_loading && valid) begin
                if (m_pos == 0) begin
                    m_total = (data == 8'h00) ? 256 : int'(data);
                    m_xor   = 8'h00;
                    m_pos   = 1;
                end else if (m_pos <= m_total) begin
                    m_we     = 1;
                    m_wdata  = data;
                    m_waddr0 = 8'(m_pos - 1);
                    m_waddr1 = 8'(254 + m_pos - 1);
                    m_xor    = m_xor ^ data;
                    m_pos++;
                end else begin
                    m_loading = 0;
                    if (data == m_xor) m_good = 1;
                    else m_failed = 1;
                    m_age = 0;
                end
            end else if (start && !m_loading) begin
                m_loading = 1; m_pos = 0; m_good = 0; m_failed = 0;
            end
            if (m_good && was_good && m_age < 2) m_age++;
            m_run = m_good && (m_age >= 1);
        end
    end

    logic [15:0] wlog0[$];
    logic [15:0] wlog1[$];
    logic [7:0]  frame[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic cycle_checker();
        logic [31:0] act, exp;
        forever begin
            @(negedge clk);
            if (m_valid) begin
                exp = {10'd0, m_loading, m_we, m_waddr0, m_wdata, !m_run, m_run, m_loading, m_failed};
                act = {10'd0, rdy0, we0, wa0, wd0, cr0, run0, busy0, err0};
                check("cycle dut0", act, exp);
                exp = {10'd0, m_loading, m_we, m_waddr1, m_wdata, !m_run, m_run, m_loading, m_failed};
                act = {10'd0, rdy1, we1, wa1, wd1, cr1, run1, busy1, err1};
                check("cycle dut1", act, exp);
                if (we0 === 1'b1) wlog0.push_back({wa0, wd0});
                if (we1 === 1'b1) wlog1.push_back({wa1, wd1});
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stall);
        int guard = 0;
        bit took;
        forever begin
            if (stall && $urandom_range(0, 2) == 0) begin
                valid = 1'b0;
                data  = 8'($urandom);
                if ($urandom_range(0, 3) == 0) start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end else begin
                valid = 1'b1;
                data  = b;
                took  = rdy0;
                @(negedge clk);
                if (took) break;
            end
            guard++;
            if (guard > 64) begin
                checks++; errors++;
                $display("FAIL send_byte timeout: IN_READY=%b, want 1", rdy0);
                break;
            end
        end
        valid = 1'b0;
    endtask

    task automatic send_frame(input bit stall);
        foreach (frame[i]) send_byte(frame[i], stall);
    endtask

    task automatic build_frame(input int n, input bit good);
        logic [7:0] x = 8'h00;
        logic [7:0] b;
        frame.delete();
        frame.push_back(8'(n));
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            frame.push_back(b);
            x ^= b;
        end
        frame.push_back(good ? x : (x ^ 8'($urandom_range(1, 255))));
    endtask

    initial begin
        int b0, b1;
        logic [15:0] e3[3];
        logic [15:0] e4[4];
        rst = 1'b1; start = 1'b0; valid = 1'b0; data = 8'h00;
        fork cycle_checker(); join_none
        idle(2);
        rst = 1'b0;
        check("reset outputs", {10'd0, rdy0, we0, wa0, wd0, cr0, run0, busy0, err0},
              {10'd0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0});

        // Bad checksum frame: writes happen, CPU stays held.
        b0 = wlog0.size(); b1 = wlog1.size();
        do_start();
        frame = '{8'h03, 8'hA1, 8'hB2, 8'hC3, 8'h50};
        send_frame(0);
        idle(3);
        check("bad frame write count", wlog0.size() - b0, 3);
        e3 = '{16'h00A1, 16'h01B2, 16'h02C3};
        for (int i = 0; i < 3; i++) check("bad frame write dut0", wlog0[b0 + i], e3[i]);
        e3 = '{16'hFEA1, 16'hFFB2, 16'h00C3};
        for (int i = 0; i < 3; i++) check("bad frame write dut1", wlog1[b1 + i], e3[i]);
        check("bad frame ERR", err0, 1);
        check("bad frame RUN", run0, 0);
        check("bad frame CPU_RESET", cr0, 1);

        // Good checksum: RUN rises one cycle after the checksum accept.
        do_start();
        frame = '{8'h03, 8'hA1, 8'hB2, 8'hC3, 8'hD0};
        send_frame(0);
        check("good frame RUN early", run0, 0);
        idle(1);
        check("good frame RUN", run0, 1);
        check("good frame CPU_RESET", cr0, 0);
        check("good frame ERR", err0, 0);

        // Backpressure with IN_VALID 1,0,0,1 and address wrap on dut1.
        b0 = wlog0.size(); b1 = wlog1.size();
        do_start();
        send_byte(8'h04, 0);
        send_byte(8'h11, 0);
        idle(2);
        send_byte(8'h22, 0);
        idle(2);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        send_byte(8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44, 0);
        idle(3);
        check("backpressure write count", wlog0.size() - b0, 4);
        e4 = '{16'h0011, 16'h0122, 16'h0233, 16'h0344};
        for (int i = 0; i < 4; i++) check("backpressure write dut0", wlog0[b0 + i], e4[i]);
        e4 = '{16'hFE11, 16'hFF22, 16'h0033, 16'h0144};
        for (int i = 0; i < 4; i++) check("wrap write dut1", wlog1[b1 + i], e4[i]);

        // START during DATA is ignored.
        b0 = wlog0.size();
        do_start();
        send_byte(8'h05, 0);
        send_byte(8'h01, 0);
        do_start();
        send_byte(8'h02, 0);
        send_byte(8'h03, 0);
        send_byte(8'h04, 0);
        send_byte(8'h05, 0);
        send_byte(8'h01, 0);
        idle(2);
        check("busy start write count", wlog0.size() - b0, 5);
        check("busy start last addr", wlog0[b0 + 4], 16'h0405);
        check("busy start RUN", run0, 1);

        // Reload from DONE drops RUN on the next edge.
        do_start();
        check("reload RUN dropped", run0, 0);
        check("reload CPU_RESET", cr0, 1);
        build_frame(6, 1);
        send_frame(1);
        idle(2);
        check("reload ERR", err0, 0);
        check("reload RUN", run0, 1);

        // Reset mid-load, coinciding with a data byte on the bus.
        b0 = wlog0.size();
        do_start();
        send_byte(8'h05, 0);
        send_byte(8'h10, 0);
        send_byte(8'h20, 0);
        rst = 1'b1; valid = 1'b1; data = 8'h30;
        @(negedge clk);
        rst = 1'b0; valid = 1'b0;
        check("mid reset WE", we0, 0);
        check("mid reset IN_READY", rdy0, 0);
        check("mid reset CPU_RESET", cr0, 1);
        check("mid reset BUSY", busy0, 0);
        idle(1);
        check("mid reset write count", wlog0.size() - b0, 2);
        b0 = wlog0.size();
        do_start();
        build_frame(5, 1);
        send_frame(0);
        idle(2);
        check("after reset write count", wlog0.size() - b0, 5);
        check("after reset RUN", run0, 1);

        // Length zero means a full 256-byte load.
        b0 = wlog0.size(); b1 = wlog1.size();
        do_start();
        build_frame(256, 1);
        send_frame(0);
        idle(3);
        check("full length write count", wlog0.size() - b0, 256);
        check("full length last addr dut1", wlog1[b1 + 255][15:8], 8'hFD);
        check("full length RUN", run0, 1);

        // Randomized frames with stalls, stray STARTs and mixed checksums.
        for (int f = 0; f < 30; f++) begin
            do_start();
            build_frame($urandom_range(1, 24), 1'($urandom_range(0, 1)));
            send_frame(1);
            idle($urandom_range(0, 3));
        end
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
